ascon_perm_ctrl: RTL and testbench

ASCON_PERM_CTRL -- requirements
Module: ascon_perm_ctrl

---
 rtl/ascon_pkg.sv | 29 ++
 rtl/ascon_round.sv | 48 ++++
 rtl/ascon_perm_ctrl.sv | 122 ++++++++++++
 tb/tb_ascon_perm_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - opcodes, op encodings, state geometry and round helpers for the Ascon coprocessor
package ascon_pkg;

  localparam logic [6:0] CUSTOM_0 = 7'b0001011;
  localparam logic [6:0] CUSTOM_1 = 7'b0101011;
  localparam logic [6:0] CUSTOM_2 = 7'b1011011;
  localparam logic [6:0] CUSTOM_3 = 7'b1111011;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_PERM = 2'b10;

  localparam int NUM_WORDS  = 5;
  localparam int NUM_ROUNDS = 12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic [7:0] round_const(input logic [3:0] i);
    return {4'hF - i, i};
  endfunction

  function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned r);
    return (x >> r) | (x << (64 - r));
  endfunction

endpackage

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational Ascon round: constant addition, S-box layer, linear layer
module ascon_round
  import ascon_pkg::*;
(
  input  logic [319:0] state_i,
  input  logic [3:0]   round_i,
  output logic [319:0] state_o
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  always_comb begin
    x0 = state_i[0*64 +: 64];
    x1 = state_i[1*64 +: 64];
    x2 = state_i[2*64 +: 64];
    x3 = state_i[3*64 +: 64];
    x4 = state_i[4*64 +: 64];

    x2 = x2 ^ {56'h0, round_const(round_i)};

    // bitsliced 5-bit S-box
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    state_o = {x4 ^ ror64(x4, 7)  ^ ror64(x4, 41),
               x3 ^ ror64(x3, 10) ^ ror64(x3, 17),
               x2 ^ ror64(x2, 1)  ^ ror64(x2, 6),
               x1 ^ ror64(x1, 61) ^ ror64(x1, 39),
               x0 ^ ror64(x0, 19) ^ ror64(x0, 28)};
  end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// rtl/ascon_perm_ctrl.sv - Ascon state coprocessor: word write/read and a multi-cycle permutation
module ascon_perm_ctrl
  import ascon_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic        cop_clk,
  input  logic        cop_rst,
  input  logic        cop_valid,
  input  logic        cop_rdywr,
  output logic        cop_ready,
  output logic        cop_wait,
  output logic        cop_wr,
  input  logic [31:0] cop_insn,
  input  logic [63:0] cop_rs1,
  input  logic [63:0] cop_rs2,
  output logic [63:0] cop_rd
);

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [319:0] st_q, st_d;

  logic [6:0]   funct;
  logic [1:0]   op;
  logic [2:0]   idx;
  logic         selected;
  logic         idx_ok;
  logic         accept;
  logic [3:0]   perm_n;
  logic [4:0]   remaining;
  logic [4:0]   step;
  logic [4:0]   next_round;
  logic         unused_bits;

  logic [UNROLL:0][319:0] chain;

  assign funct    = cop_insn[31:25];
  assign op       = funct[6:5];
  assign idx      = funct[2:0];
  assign selected = (cop_insn[6:0] == CUSTOM_2) && (op != 2'b11);
  assign idx_ok   = ({29'd0, idx} < NUM_WORDS);
  assign accept   = cop_valid & selected & cop_ready;
  assign perm_n   = (cop_rs1[3:0] > 4'(NUM_ROUNDS)) ? 4'(NUM_ROUNDS) : cop_rs1[3:0];

  assign unused_bits = ^{cop_rs2, cop_insn[24:7], funct[4:3]};

  // Stages past round 11 pass their input through, so the last cycle never overshoots.
  assign chain[0] = st_q;
  for (genvar k = 0; k < UNROLL; k++) begin : g_stage
    logic [4:0]   rnd;
    logic [319:0] rnd_out;
    assign rnd = {1'b0, round_q} + 5'(k);
    ascon_round u_round (
      .state_i (chain[k]),
      .round_i (rnd[3:0]),
      .state_o (rnd_out)
    );
    assign chain[k+1] = (rnd < 5'(NUM_ROUNDS)) ? rnd_out : chain[k];
  end

  assign remaining  = 5'(NUM_ROUNDS) - {1'b0, round_q};
  assign step       = (remaining > 5'(UNROLL)) ? 5'(UNROLL) : remaining;
  assign next_round = {1'b0, round_q} + step;

  always_ff @(posedge cop_clk or negedge cop_rst) begin
    if (!cop_rst) begin
      state_q <= ST_IDLE;
      round_q <= 4'd0;
      st_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      st_q    <= st_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    st_d    = st_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == OP_WR && idx_ok) begin
            st_d[{idx, 6'b0} +: 64] = cop_rs1;
          end else if (op == OP_PERM && perm_n != 4'd0) begin
            state_d = ST_BUSY;
            round_d = 4'(NUM_ROUNDS) - perm_n;
          end
        end
      end
      ST_BUSY: begin
        st_d = chain[UNROLL];
        if (next_round >= 5'(NUM_ROUNDS)) begin
          state_d = ST_IDLE;
          round_d = 4'd0;
        end else begin
          round_d = next_round[3:0];
        end
      end
      default: begin
        state_d = ST_IDLE;
        round_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    cop_wait = (state_q == ST_BUSY);
    cop_wr   = cop_valid & selected & (op == OP_RD) & (state_q == ST_IDLE);
    cop_rd   = (cop_wr && idx_ok) ? st_q[{idx, 6'b0} +: 64] : 64'h0;
    if (!selected) begin
      cop_ready = 1'b1;
    end else if (state_q == ST_BUSY) begin
      cop_ready = 1'b0;
    end else begin
      cop_ready = ~(cop_wr & ~cop_rdywr);
    end
  end

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// tb/tb_ascon_perm_ctrl.sv - scoreboard bench running UNROLL=1 and UNROLL=3 instances in lockstep
module tb_ascon_perm_ctrl;

  logic        cop_clk = 1'b0;
  logic        cop_rst;
  logic        cop_valid;
  logic        cop_rdywr;
  logic [31:0] cop_insn;
  logic [63:0] cop_rs1;
  logic [63:0] cop_rs2;

  logic        ready1, wait1, wr1;
  logic [63:0] rd1;
  logic        ready3, wait3, wr3;
  logic [63:0] rd3;

  int checks   = 0;
  int failures = 0;

  logic [63:0] mdl [5];
  logic [63:0] exp_q [$];
  logic [4:0]  sbox [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                             5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                             5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                             5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  always #5 cop_clk = ~cop_clk;

  ascon_perm_ctrl #(.UNROLL(1)) u1 (
    .cop_clk(cop_clk), .cop_rst(cop_rst), .cop_valid(cop_valid), .cop_rdywr(cop_rdywr),
    .cop_ready(ready1), .cop_wait(wait1), .cop_wr(wr1), .cop_insn(cop_insn),
    .cop_rs1(cop_rs1), .cop_rs2(cop_rs2), .cop_rd(rd1)
  );

  ascon_perm_ctrl #(.UNROLL(3)) u3 (
    .cop_clk(cop_clk), .cop_rst(cop_rst), .cop_valid(cop_valid), .cop_rdywr(cop_rdywr),
    .cop_ready(ready3), .cop_wait(wait3), .cop_wr(wr3), .cop_insn(cop_insn),
    .cop_rs1(cop_rs1), .cop_rs2(cop_rs2), .cop_rd(rd3)
  );

  function automatic logic [31:0] mk_insn(input logic [1:0] op, input logic [2:0] idx);
    return {op, 2'b00, idx, 18'h0, 7'b1011011};
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int r);
    return (x >> r) | (x << (64 - r));
  endfunction

  task automatic model_round(input int i);
    logic [4:0] v, s;
    mdl[2] = mdl[2] ^ {56'h0, 8'hF0 - 8'(15 * i)};
    for (int b = 0; b < 64; b++) begin
      v = {mdl[0][b], mdl[1][b], mdl[2][b], mdl[3][b], mdl[4][b]};
      s = sbox[v];
      mdl[0][b] = s[4];
      mdl[1][b] = s[3];
      mdl[2][b] = s[2];
      mdl[3][b] = s[1];
      mdl[4][b] = s[0];
    end
    mdl[0] = mdl[0] ^ rotr(mdl[0], 19) ^ rotr(mdl[0], 28);
    mdl[1] = mdl[1] ^ rotr(mdl[1], 61) ^ rotr(mdl[1], 39);
    mdl[2] = mdl[2] ^ rotr(mdl[2], 1)  ^ rotr(mdl[2], 6);
    mdl[3] = mdl[3] ^ rotr(mdl[3], 10) ^ rotr(mdl[3], 17);
    mdl[4] = mdl[4] ^ rotr(mdl[4], 7)  ^ rotr(mdl[4], 41);
  endtask

  task automatic model_perm(input int n);
    for (int i = 12 - n; i < 12; i++) model_round(i);
  endtask

  task automatic idle_inputs();
    cop_valid = 1'b0;
    cop_insn  = 32'h0;
    cop_rs1   = 64'h0;
    cop_rs2   = 64'h0;
    cop_rdywr = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((wait1 || wait3) && n < 100) begin
      @(negedge cop_clk);
      n++;
    end
    checks++;
    if (wait1 || wait3) begin
      failures++;
      $display("FAIL wait_idle: cop_wait u1=%0b u3=%0b still high after %0d cycles, required 0", wait1, wait3, n);
    end
  endtask

  task automatic write_word(input logic [2:0] idx, input logic [63:0] val);
    wait_idle();
    cop_valid = 1'b1;
    cop_insn  = mk_insn(2'b00, idx);
    cop_rs1   = val;
    cop_rs2   = ~val;
    @(negedge cop_clk);
    idle_inputs();
  endtask

  task automatic read_check(input int idx, input string name);
    logic [63:0] e;
    exp_q.push_back((idx < 5) ? mdl[idx] : 64'h0);
    wait_idle();
    cop_valid = 1'b1;
    cop_insn  = mk_insn(2'b01, 3'(idx));
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({wr1, rd1, wr3, rd3} !== {1'b1, e, 1'b1, e}) begin
      failures++;
      $display("FAIL %s rd[%0d]: wr1=%0b rd1=%h wr3=%0b rd3=%h, required wr=1 rd=%h", name, idx, wr1, rd1, wr3, rd3, e);
    end
    @(negedge cop_clk);
    idle_inputs();
  endtask

  task automatic read_all(input string name);
    for (int i = 0; i < 5; i++) read_check(i, name);
  endtask

  task automatic load_random();
    for (int i = 0; i < 5; i++) begin
      mdl[i] = {$urandom, $urandom};
      write_word(3'(i), mdl[i]);
    end
  endtask

  task automatic run_perm(input logic [63:0] rs1, input int n_model, input int exp_c1, input int exp_c3,
                          input logic [7:0] exp_first, input logic [7:0] exp_last, input string name);
    int c1 = 0, c3 = 0, t = 0, li;
    logic [7:0] f1 = 8'h0, l1 = 8'h0, f3 = 8'h0, l3 = 8'h0;
    wait_idle();
    cop_valid = 1'b1;
    cop_insn  = mk_insn(2'b10, 3'd0);
    cop_rs1   = rs1;
    @(negedge cop_clk);
    idle_inputs();
    while ((wait1 || wait3) && t < 40) begin
      if (wait1) begin
        if (c1 == 0) f1 = ascon_pkg::round_const(u1.round_q);
        l1 = ascon_pkg::round_const(u1.round_q);
      end
      if (wait3) begin
        if (c3 == 0) f3 = ascon_pkg::round_const(u3.round_q);
        li = int'(u3.round_q) + 2;
        if (li > 11) li = 11;
        l3 = ascon_pkg::round_const(4'(li));
      end
      c1 += int'(wait1);
      c3 += int'(wait3);
      @(negedge cop_clk);
      t++;
    end
    model_perm(n_model);
    checks++;
    if (c1 !== exp_c1 || c3 !== exp_c3) begin
      failures++;
      $display("FAIL %s busy cycles: u1=%0d u3=%0d, required u1=%0d u3=%0d", name, c1, c3, exp_c1, exp_c3);
    end
    checks++;
    if ({f1, f3, l1, l3} !== {exp_first, exp_first, exp_last, exp_last}) begin
      failures++;
      $display("FAIL %s constants: first u1=%h u3=%h last u1=%h u3=%h, required first=%h last=%h",
               name, f1, f3, l1, l3, exp_first, exp_last);
    end
    read_all(name);
  endtask

  task automatic test_reset();
    idle_inputs();
    cop_rst = 1'b0;
    for (int i = 0; i < 5; i++) mdl[i] = 64'h0;
    repeat (2) @(negedge cop_clk);
    checks++;
    if ({wait1, wr1, rd1, ready1, wait3, wr3, rd3, ready3} !== {1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset outputs: wait=%0b/%0b wr=%0b/%0b rd=%h/%h ready=%0b/%0b, required wait=0 wr=0 rd=0 ready=1",
               wait1, wait3, wr1, wr3, rd1, rd3, ready1, ready3);
    end
    cop_rst = 1'b1;
    @(negedge cop_clk);
    read_all("reset_state");
  endtask

  task automatic test_wr_rd();
    mdl[2] = 64'h0123456789ABCDEF;
    write_word(3'd2, 64'h0123456789ABCDEF);
    read_check(2, "wr_rd");
    read_check(7, "rd_idx7");
    write_word(3'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    read_all("wr_idx5_noop");
  endtask

  task automatic test_unselected();
    wait_idle();
    cop_valid = 1'b1;
    cop_insn  = {7'b0100010, 18'h0, 7'b0001011};
    #1;
    checks++;
    if ({ready1, wr1, ready3, wr3} !== 4'b1010) begin
      failures++;
      $display("FAIL unselected custom0: ready=%0b/%0b wr=%0b/%0b, required ready=1 wr=0", ready1, ready3, wr1, wr3);
    end
    @(negedge cop_clk);
    cop_insn = mk_insn(2'b11, 3'd1);
    cop_rs1  = 64'hDEAD_BEEF_0000_0000;
    #1;
    checks++;
    if ({ready1, wr1, ready3, wr3} !== 4'b1010) begin
      failures++;
      $display("FAIL unselected funct11: ready=%0b/%0b wr=%0b/%0b, required ready=1 wr=0", ready1, ready3, wr1, wr3);
    end
    @(negedge cop_clk);
    cop_valid = 1'b0;
    cop_insn  = mk_insn(2'b00, 3'd0);
    @(negedge cop_clk);
    idle_inputs();
    read_all("no_state_change");
  endtask

  task automatic test_rd_busy();
    int busy = 0, t = 0;
    logic done = 1'b0;
    logic [63:0] e;
    load_random();
    wait_idle();
    cop_valid = 1'b1;
    cop_insn  = mk_insn(2'b10, 3'd0);
    cop_rs1   = 64'd12;
    @(negedge cop_clk);
    model_perm(12);
    exp_q.push_back(mdl[3]);
    cop_insn = mk_insn(2'b01, 3'd3);
    cop_rs1  = 64'h0;
    while (!done && t < 40) begin
      #1;
      if (wait1) begin
        busy++;
        checks++;
        if ({ready1, wr1} !== 2'b00) begin
          failures++;
          $display("FAIL rd_busy stall cycle %0d: ready=%0b wr=%0b, required ready=0 wr=0", busy, ready1, wr1);
        end
      end else begin
        e = exp_q.pop_front();
        checks++;
        if ({ready1, wr1, rd1} !== {1'b1, 1'b1, e}) begin
          failures++;
          $display("FAIL rd_busy result: ready=%0b wr=%0b rd=%h, required ready=1 wr=1 rd=%h", ready1, wr1, rd1, e);
        end
        done = 1'b1;
      end
      @(negedge cop_clk);
      t++;
    end
    idle_inputs();
    checks++;
    if (busy !== 12 || !done) begin
      failures++;
      $display("FAIL rd_busy stall length: %0d cycles done=%0b, required 12 cycles done=1", busy, done);
    end
  endtask

  task automatic test_rdywr();
    logic [63:0] e;
    exp_q.push_back(mdl[1]);
    wait_idle();
    cop_valid = 1'b1;
    cop_insn  = mk_insn(2'b01, 3'd1);
    cop_rdywr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({ready1, wr1, ready3, wr3} !== 4'b0101) begin
        failures++;
        $display("FAIL rdywr stall cycle %0d: ready=%0b/%0b wr=%0b/%0b, required ready=0 wr=1", c, ready1, ready3, wr1, wr3);
      end
      @(negedge cop_clk);
    end
    cop_rdywr = 1'b1;
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({ready1, wr1, rd1, ready3, wr3, rd3} !== {1'b1, 1'b1, e, 1'b1, 1'b1, e}) begin
      failures++;
      $display("FAIL rdywr accept: ready=%0b/%0b wr=%0b/%0b rd=%h/%h, required ready=1 wr=1 rd=%h",
               ready1, ready3, wr1, wr3, rd1, rd3, e);
    end
    @(negedge cop_clk);
    idle_inputs();
  endtask

  task automatic test_reset_busy();
    int busy = 0, t = 0;
    load_random();
    wait_idle();
    cop_valid = 1'b1;
    cop_insn  = mk_insn(2'b10, 3'd0);
    cop_rs1   = 64'd12;
    @(negedge cop_clk);
    idle_inputs();
    while (busy < 5 && t < 40) begin
      busy += int'(wait1);
      if (busy < 5) @(negedge cop_clk);
      t++;
    end
    cop_rst = 1'b0;
    for (int i = 0; i < 5; i++) mdl[i] = 64'h0;
    #1;
    checks++;
    if ({busy == 5, wait1, wait3} !== 3'b100) begin
      failures++;
      $display("FAIL reset_busy: reached busy=%0d wait=%0b/%0b, required busy=5 wait=0", busy, wait1, wait3);
    end
    @(negedge cop_clk);
    cop_rst = 1'b1;
    @(negedge cop_clk);
    checks++;
    if ({wait1, wait3} !== 2'b00) begin
      failures++;
      $display("FAIL reset_busy after release: wait=%0b/%0b, required 0", wait1, wait3);
    end
    read_all("reset_busy");
  endtask

  initial begin
    test_reset();
    test_wr_rd();
    test_unselected();
    load_random();
    run_perm(64'd12, 12, 12, 4, 8'hF0, 8'h4B, "perm12");
    run_perm(64'd6, 6, 6, 2, 8'h96, 8'h4B, "perm6");
    load_random();
    run_perm(64'hA5A5_0000_0000_000F, 12, 12, 4, 8'hF0, 8'h4B, "perm15");
    run_perm(64'hFFFF_FFFF_FFFF_FFF0, 0, 0, 0, 8'h00, 8'h00, "perm0");
    test_rd_busy();
    test_rdywr();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
